uart_rx: RTL and testbench

//   UART receiver, 8N1, LSB first. It is the receive-side counterpart of uart_tx in the same design.

---
 rtl/uart_rx.sv | 122 ++++++++++++
 tb/tb_uart_rx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: 2-FF synchroniser, start-bit centring,
// mid-bit sampling, one-cycle valid / frame-error strobes.
module uart_rx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_uart_rx,
   output logic [7:0] o_uart_data,
   output logic       o_uart_valid,
   output logic       o_uart_frame_err,
   output logic       o_uart_busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   logic          rx_meta;
   logic          rx_s;
   logic          rx_s_d;
   logic          fall;

   // Synchroniser flops reset high so a held-idle line never looks like a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_s_d  <= 1'b1;
      end else begin
         rx_meta <= i_uart_rx;
         rx_s    <= rx_meta;
         rx_s_d  <= rx_s;
      end
   end

   assign fall = rx_s_d & ~rx_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         cnt              <= '0;
         idx              <= '0;
         shreg            <= '0;
         o_uart_data      <= '0;
         o_uart_valid     <= 1'b0;
         o_uart_frame_err <= 1'b0;
         o_uart_busy      <= 1'b0;
      end else begin
         o_uart_valid     <= 1'b0;
         o_uart_frame_err <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (fall) begin
                  state       <= START;
                  o_uart_busy <= 1'b1;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  // A start bit that is high again at its centre was only a glitch.
                  if (!rx_s) begin
                     state <= DATA;
                     idx   <= '0;
                  end else begin
                     state       <= IDLE;
                     o_uart_busy <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt        <= '0;
                  shreg[idx] <= rx_s;
                  if (idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               // Leaving at mid-stop-bit leaves room for a start edge with no idle gap.
               if (cnt == BIT_LAST) begin
                  cnt         <= '0;
                  state       <= IDLE;
                  o_uart_busy <= 1'b0;
                  if (rx_s) begin
                     o_uart_data  <= shreg;
                     o_uart_valid <= 1'b1;
                  end else begin
                     o_uart_frame_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               cnt         <= '0;
               o_uart_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: bit-timed line driver, expected-event queue scoreboard,
// table of directed frames, hand sequences for timing corners, random frames.
module tb_uart_rx;

   localparam int CLK_FREQ  = 50_000_000;
   localparam int BAUD_RATE = 2_500_000;
   localparam int CPB       = CLK_FREQ / BAUD_RATE;   // 20 clocks per bit
   localparam int HALF      = CPB / 2;
   localparam int BIT_T     = CPB * 20;               // clock period is 20 time units
   localparam int LATENCY   = 9 * CPB + HALF + 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] o_uart_data;
   logic       o_uart_valid;
   logic       o_uart_frame_err;
   logic       o_uart_busy;

   int checks   = 0;
   int failures = 0;

   // Expected events: {is_frame_err, data seen on o_uart_data at the strobe}
   logic [8:0] exp_q[$];
   logic [7:0] model_last;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         bit_t;
      int         gap;
      logic       exp_err;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[8];

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_uart_rx        (rx),
      .o_uart_data      (o_uart_data),
      .o_uart_valid     (o_uart_valid),
      .o_uart_frame_err (o_uart_frame_err),
      .o_uart_busy      (o_uart_busy)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Line is left at the stop-bit level; callers drive idle explicitly.
   task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_t);
      rx = 1'b0;
      #(bit_t);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         #(bit_t);
      end
      rx = stop;
      #(bit_t);
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      #(n * BIT_T);
   endtask

   task automatic expect_frame(input logic [7:0] d, input logic stop);
      if (stop) begin
         exp_q.push_back({1'b0, d});
         model_last = d;
      end else begin
         exp_q.push_back({1'b1, model_last});
      end
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s: %0d expected events never seen within %0d cycles",
                  name, exp_q.size(), budget);
         exp_q.delete();
      end
   endtask

   // Scoreboard: every strobe must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst && (o_uart_valid || o_uart_frame_err)) begin
         check("strobe_exclusive", {31'd0, o_uart_valid & o_uart_frame_err}, 32'd0);
         check("busy_low_at_strobe", {31'd0, o_uart_busy}, 32'd0);
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_strobe: got valid=%0b err=%0b data=%0h expected none",
                     o_uart_valid, o_uart_frame_err, o_uart_data);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            if ({o_uart_frame_err, o_uart_data} !== e) begin
               failures++;
               $display("FAIL event: got err=%0b data=%0h expected err=%0b data=%0h",
                        o_uart_frame_err, o_uart_data, e[8], e[7:0]);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int cyc;
      logic busy_mid;

      vecs[0] = '{8'h66, 1'b1, BIT_T,       0, 1'b0, 8'h66};
      vecs[1] = '{8'h00, 1'b1, BIT_T,       0, 1'b0, 8'h00};
      vecs[2] = '{8'hFF, 1'b1, BIT_T,       1, 1'b0, 8'hFF};
      vecs[3] = '{8'h3C, 1'b0, BIT_T,       1, 1'b1, 8'hFF};
      vecs[4] = '{8'hC3, 1'b1, BIT_T + 8,   1, 1'b0, 8'hC3};
      vecs[5] = '{8'hC3, 1'b1, BIT_T - 8,   1, 1'b0, 8'hC3};
      vecs[6] = '{8'h81, 1'b1, BIT_T,       0, 1'b0, 8'h81};
      vecs[7] = '{8'h7E, 1'b0, BIT_T - 8,   2, 1'b1, 8'h81};

      // Reset state
      model_last = 8'h00;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_data", {24'd0, o_uart_data}, 32'h0);
      check("reset_valid", {31'd0, o_uart_valid}, 32'd0);
      check("reset_err", {31'd0, o_uart_frame_err}, 32'd0);
      check("reset_busy", {31'd0, o_uart_busy}, 32'd0);
      idle_bits(2);

      // Single frame: latency and busy across the frame
      @(negedge clk);
      expect_frame(8'hA5, 1'b1);
      cyc = 0;
      busy_mid = 1'b0;
      fork
         send_frame(8'hA5, 1'b1, BIT_T);
         begin
            while (!o_uart_valid && cyc < 2 * LATENCY) begin
               @(negedge clk);
               cyc++;
               if (cyc == 5 * CPB) busy_mid = o_uart_busy;
            end
         end
      join
      check("busy_mid_frame", {31'd0, busy_mid}, 32'd1);
      checks++;
      if (cyc < LATENCY - 1 || cyc > LATENCY + 1) begin
         failures++;
         $display("FAIL latency: got %0d cycles expected %0d +-1", cyc, LATENCY);
      end
      idle_bits(1);
      wait_drain("a5_frame", 4 * CPB);
      check("a5_data_held", {24'd0, o_uart_data}, 32'hA5);

      // Directed frames: back-to-back, framing error, +-2% bit period
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back({vecs[i].exp_err, vecs[i].exp_data});
         if (!vecs[i].exp_err) model_last = vecs[i].exp_data;
         send_frame(vecs[i].data, vecs[i].stop, vecs[i].bit_t);
         idle_bits(vecs[i].gap);
      end
      wait_drain("vector_table", 4 * CPB);

      // Short low glitch on an idle line
      @(negedge clk);
      rx = 1'b0;
      #100;
      rx = 1'b1;
      check("glitch_busy_rises", {31'd0, o_uart_busy}, 32'd1);
      repeat (HALF + 1) @(negedge clk);
      check("glitch_busy_falls", {31'd0, o_uart_busy}, 32'd0);
      idle_bits(2);

      // Framing error with the line then held low: no frame until a fresh falling edge
      expect_frame(8'h12, 1'b0);
      send_frame(8'h12, 1'b0, BIT_T);
      #(3 * BIT_T);
      check("held_low_idle", {31'd0, o_uart_busy}, 32'd0);
      idle_bits(1);
      expect_frame(8'h34, 1'b1);
      send_frame(8'h34, 1'b1, BIT_T);
      idle_bits(1);
      wait_drain("held_low", 4 * CPB);

      // Reset pulse during data bit 4; upper bits of 8'hF0 keep the line high afterwards
      fork
         send_frame(8'hF0, 1'b1, BIT_T);
         begin
            #(5 * BIT_T + BIT_T / 2);
            @(negedge clk);
            check("busy_before_rst", {31'd0, o_uart_busy}, 32'd1);
            rst = 1'b1;
            @(negedge clk);
            check("rst_mid_data", {24'd0, o_uart_data}, 32'h0);
            check("rst_mid_valid", {31'd0, o_uart_valid}, 32'd0);
            check("rst_mid_err", {31'd0, o_uart_frame_err}, 32'd0);
            check("rst_mid_busy", {31'd0, o_uart_busy}, 32'd0);
            rst = 1'b0;
            model_last = 8'h00;
         end
      join
      idle_bits(2);
      expect_frame(8'h5A, 1'b1);
      send_frame(8'h5A, 1'b1, BIT_T);
      idle_bits(1);
      wait_drain("after_reset", 4 * CPB);

      // Random frames against the reference model
      for (int i = 0; i < 24; i++) begin
         logic [7:0] d;
         logic       stop;
         int         bt;
         int         gap;
         d    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 3) != 0);
         bt   = $urandom_range(BIT_T - 8, BIT_T + 8);
         gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
         expect_frame(d, stop);
         send_frame(d, stop, bt);
         idle_bits(gap);
      end
      idle_bits(1);
      wait_drain("random", 4 * CPB);
      check("final_data", {24'd0, o_uart_data}, {24'd0, model_last});
      idle_bits(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
